// File: rtl/example_and_gate_pkg.sv
// Shared defaults and helpers for the example_and_gate block and its saturating counter.
// Operand width defaults to a single-bit gate; the counter width covers long runs.
package example_and_gate_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // Increment that refuses to wrap past the all-ones value.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] limit;
        limit = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= limit) ? limit : value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and holds at all ones.
// The sat flag is a pure decode of the count, so it follows the register directly.
import example_and_gate_pkg::*;

module sat_counter #(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [63:0] next_wide;

    assign sat = (count == {CNT_W{1'b1}});

    always_comb begin
        next_wide = sat_inc(64'(count), CNT_W);
    end

    // Reset wins over an increment arriving at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= next_wide[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/example_and_gate.sv
// Bitwise AND gate with a registered copy, per-bit edge pulses and a saturating
// count of cycles in which bit 0 of the AND result was high.
import example_and_gate_pkg::*;

module example_and_gate #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] output_1,
    output logic [WIDTH-1:0] output_q,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [CNT_W-1:0] true_count,
    output logic             count_sat
);

    assign output_1 = input_1 & input_2;

    // Edges are judged against the registered copy, so clearing output_q on reset
    // both drops any pending pulse and makes the first post-reset 1 look like a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_q   <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            output_q   <= output_1;
            rise_pulse <= output_1 & ~output_q;
            fall_pulse <= ~output_1 & output_q;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_true_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (output_1[0]),
        .count(true_count),
        .sat  (count_sat)
    );

endmodule

// File: tb/tb_example_and_gate.sv
// Scoreboard bench for example_and_gate at WIDTH=4, CNT_W=4: directed vectors push
// hand-computed expectations, and a monitor pops and compares after each clock edge.
module tb_example_and_gate;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    typedef struct {
        string      name;
        logic [3:0] out1;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] cnt;
        logic       sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             clk_run = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] input_1 = '0;
    logic [WIDTH-1:0] input_2 = '0;
    logic [WIDTH-1:0] output_1;
    logic [WIDTH-1:0] output_q;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [CNT_W-1:0] true_count;
    logic             count_sat;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    example_and_gate #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .input_1   (input_1),
        .input_2   (input_2),
        .output_1  (output_1),
        .output_q  (output_q),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .true_count(true_count),
        .count_sat (count_sat)
    );

    // The clock can be held idle to exercise the purely combinational path.
    always #5 if (clk_run) clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input string name, input logic r, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] out1,
                                 input logic [3:0] q, input logic [3:0] rise,
                                 input logic [3:0] fall, input logic [3:0] cnt,
                                 input logic sat);
        exp_t e;
        @(negedge clk);
        rst     = r;
        input_1 = a;
        input_2 = b;
        e.name = name; e.out1 = out1; e.q = q; e.rise = rise;
        e.fall = fall; e.cnt = cnt; e.sat = sat;
        exp_q.push_back(e);
    endtask

    // Monitor: registered outputs settle after the edge; each pushed vector owns one edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput(e.name,
                        {11'd0, output_1, output_q, rise_pulse, fall_pulse, true_count, count_sat},
                        {11'd0, e.out1, e.q, e.rise, e.fall, e.cnt, e.sat});
            checkOutput({e.name, "_excl"}, {28'd0, rise_pulse & fall_pulse}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] cnt_exp;

        // Combinational truth table with the clock idle.
        rst = 1'b0;
        input_1 = 4'b0000; input_2 = 4'b0000; #10;
        checkOutput("tt_00", {28'd0, output_1}, 32'h0);
        input_1 = 4'b0000; input_2 = 4'b1111; #10;
        checkOutput("tt_01", {28'd0, output_1}, 32'h0);
        input_1 = 4'b1111; input_2 = 4'b0000; #10;
        checkOutput("tt_10", {28'd0, output_1}, 32'h0);
        input_1 = 4'b1111; input_2 = 4'b1111; #10;
        checkOutput("tt_11", {28'd0, output_1}, 32'hF);
        input_1 = 4'b1010; input_2 = 4'b0110; #10;
        checkOutput("tt_multibit", {28'd0, output_1}, 32'h2);
        input_1 = 4'b0000; input_2 = 4'bxxxx; #10;
        checkOutput("tt_zero_vs_x", {28'd0, output_1}, 32'h0);
        rst = 1'b1; input_1 = 4'b0101; input_2 = 4'b0111; #10;
        checkOutput("tt_in_reset", {28'd0, output_1}, 32'h5);

        clk_run = 1'b1;
        //            name          rst a        b        out1     q        rise     fall     cnt sat
        applyStimulus("reset_prio", 1, 4'hF,   4'hF,   4'hF,   4'h0,   4'h0,   4'h0,   4'd0, 0);
        applyStimulus("reset_idle", 1, 4'h0,   4'h0,   4'h0,   4'h0,   4'h0,   4'h0,   4'd0, 0);
        applyStimulus("rise",       0, 4'h1,   4'h1,   4'h1,   4'h1,   4'h1,   4'h0,   4'd1, 0);
        applyStimulus("hold_high",  0, 4'h1,   4'h1,   4'h1,   4'h1,   4'h0,   4'h0,   4'd2, 0);
        applyStimulus("fall",       0, 4'h1,   4'h0,   4'h0,   4'h0,   4'h0,   4'h1,   4'd2, 0);
        applyStimulus("hold_low",   0, 4'h1,   4'h0,   4'h0,   4'h0,   4'h0,   4'h0,   4'd2, 0);
        applyStimulus("multibit",   0, 4'hA,   4'h6,   4'h2,   4'h2,   4'h2,   4'h0,   4'd2, 0);
        applyStimulus("all_ones",   0, 4'hF,   4'hF,   4'hF,   4'hF,   4'hD,   4'h0,   4'd3, 0);
        applyStimulus("partial",    0, 4'h5,   4'hF,   4'h5,   4'h5,   4'h0,   4'hA,   4'd4, 0);
        applyStimulus("rst_pend",   1, 4'h1,   4'h1,   4'h1,   4'h0,   4'h0,   4'h0,   4'd0, 0);
        applyStimulus("post_rst",   0, 4'h1,   4'h1,   4'h1,   4'h1,   4'h1,   4'h0,   4'd1, 0);

        // Hold bit 0 high long enough to drive the 4-bit counter into saturation.
        cnt_exp = 4'd1;
        for (int k = 0; k < 20; k++) begin
            if (cnt_exp != 4'd15) cnt_exp = cnt_exp + 4'd1;
            applyStimulus($sformatf("sat_%0d", k), 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                          cnt_exp, (cnt_exp == 4'd15));
        end

        applyStimulus("mid_rst",    1, 4'h1,   4'h1,   4'h1,   4'h0,   4'h0,   4'h0,   4'd0, 0);
        applyStimulus("mid_rst_up", 0, 4'h1,   4'h1,   4'h1,   4'h1,   4'h1,   4'h0,   4'd1, 0);
        applyStimulus("final_fall", 0, 4'h0,   4'h0,   4'h0,   4'h0,   4'h0,   4'h1,   4'd1, 0);

        // Bounded drain so every pushed expectation is compared.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/example_and_gate.md
EXAMPLE_AND_GATE -- requirements
Module: example_and_gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of both operands and of the result.
REQ-002 Parameter CNT_W, default 16: bit width of the true-cycle counter.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all registered outputs.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port input_1, input, WIDTH: operand A.
REQ-007 Port input_2, input, WIDTH: operand B.
REQ-008 Port output_1, output, WIDTH: combinational bitwise AND of input_1 and input_2.
REQ-009 Port output_q, output, WIDTH: output_1 registered by one clock.
REQ-010 Port rise_pulse, output, WIDTH: per-bit one-cycle pulse on a 0->1 transition of output_q.
REQ-011 Port fall_pulse, output, WIDTH: per-bit one-cycle pulse on a 1->0 transition of output_q.
REQ-012 Port true_count, output, CNT_W: count of clock cycles in which bit 0 of output_1 was 1.
REQ-013 Port count_sat, output, 1: high while true_count is at its maximum value.

Function
REQ-014 output_1 SHALL equal input_1 AND input_2, bit by bit, with zero clock latency.
REQ-015 output_1 SHALL NOT depend on clk or rst; it SHALL be valid with clk idle and during reset.
REQ-016 Truth table per bit SHALL be: 0,0->0; 0,1->0; 1,0->0; 1,1->1.
REQ-017 Any bit with an operand at 0 SHALL yield 0 even if the other operand is X/Z; all other X/Z combinations SHALL follow the simulator's AND semantics.
REQ-018 output_q SHALL take the value of output_1 at each rising clk edge, giving a latency of 1 cycle.
REQ-019 rise_pulse SHALL equal output_1 AND NOT output_q, registered, so that it is high for exactly one cycle after output_q rises.
REQ-020 fall_pulse SHALL equal NOT output_1 AND output_q, registered, using the same timing as rise_pulse.
REQ-021 rise_pulse and fall_pulse SHALL never both be high on the same bit.
REQ-022 true_count SHALL increment by 1 on each rising edge at which output_1[0] is 1.
REQ-023 true_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 count_sat SHALL be combinational from true_count, high exactly when true_count equals all ones.

Reset
REQ-025 When rst is high at a rising clk edge, output_q, rise_pulse, fall_pulse and true_count SHALL all become 0.
REQ-026 Reset SHALL take priority over increment and capture when both occur at the same edge.
REQ-027 Reset applied mid-operation SHALL suppress any pending edge pulse.
REQ-028 The first edge after reset deasserts SHALL treat the previous output_q as 0, so a 1 on output_1 SHALL produce rise_pulse one cycle later.

Structure
REQ-029 A shared package example_and_gate_pkg SHALL hold the default constants for WIDTH and CNT_W.
REQ-030 The saturating counter SHALL be one sub-module, sat_counter, with parameter CNT_W and ports clk, rst, inc, count and sat.
REQ-031 The edge detection and output register SHALL be implemented inline in the top module.

Verification
REQ-032 Truth-table check with clk idle and rst low: drive (0,0), (0,1), (1,0), (1,1), each held for 10 ns; output_1 SHALL read 0, 0, 0, 1.
REQ-033 Registered path: input_1=input_2=1 applied at edge n -> output_q=1 after edge n+1, and rise_pulse=1 for exactly one cycle.
REQ-034 Falling edge: input_2 drops to 0 -> fall_pulse=1 for one cycle, and rise_pulse stays 0.
REQ-035 Saturation with CNT_W=4: hold output_1=1 for 20 cycles -> true_count=15, count_sat=1, and no wrap.
REQ-036 Reset mid-run: assert rst for one edge during output_1=1 -> true_count=0, output_q=0 and pulses=0, while output_1 stays 1 throughout.
REQ-037 Multi-bit check with WIDTH=4: input_1=1010 and input_2=0110 -> output_1=0010 immediately, and output_q=0010 one cycle later.
